// File: rtl/haz_pkg.sv
// Shared types and helpers for the pipeline hazard scoreboard.
package haz_pkg;

  localparam int unsigned FWD_RF    = 0;
  // Widest register address a scoreboard slot can hold; narrower addresses are zero-extended.
  localparam int unsigned RegAwMax  = 8;

  typedef struct packed {
    logic                valid;
    logic [RegAwMax-1:0] rd;
    logic                is_load;
  } sb_slot_t;

  function automatic int unsigned fwd_w(input int unsigned fwd_stages);
    return $clog2(fwd_stages + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// ID-stage request and hazard-control bundle between the decode stage and the scoreboard.
interface pipe_hazard_scoreboard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned FW     = 2
);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_is_load;
  logic              redirect;
  logic              en_pc;
  logic              en_ifid;
  logic              flush_ifid;
  logic              bubble_idex;
  logic [FW-1:0]     fwd_a;
  logic [FW-1:0]     fwd_b;
  logic [31:0]       perf_stalls;
  logic [31:0]       perf_flushes;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_is_load,
           redirect,
    input  en_pc, en_ifid, flush_ifid, bubble_idex, fwd_a, fwd_b, perf_stalls, perf_flushes
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_is_load,
           redirect,
    output en_pc, en_ifid, flush_ifid, bubble_idex, fwd_a, fwd_b, perf_stalls, perf_flushes
  );

endinterface

// File: rtl/haz_src_match.sv
// Matches one source register against all scoreboard slots; the youngest valid producer wins.
module haz_src_match
  import haz_pkg::*;
#(
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned FW         = 2
) (
  input  logic [RegAwMax-1:0]         rs,
  input  logic                        use_rs,
  input  sb_slot_t [FWD_STAGES-1:0]   slots,
  output logic [FW-1:0]               index,
  output logic                        hit,
  output logic                        is_load
);

  // Scan oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    index   = FW'(FWD_RF);
    hit     = 1'b0;
    is_load = 1'b0;
    for (int j = int'(FWD_STAGES) - 1; j >= 0; j--) begin
      if (use_rs && (rs != '0) && slots[j].valid && (slots[j].rd == rs)) begin
        index   = FW'(j + 1);
        hit     = 1'b1;
        is_load = slots[j].is_load;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Forwarding / load-use / redirect hazard unit beside the ID stage.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_scoreboard
  import haz_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned KILL_SLOTS = 1
) (
  input logic                     clk,
  input logic                     rst,
  pipe_hazard_scoreboard_if.slave bus
);

  localparam int unsigned      FW      = fwd_w(FWD_STAGES);
  localparam logic [FW-1:0]    LoadIdx = FW'(LOAD_LAT);

  sb_slot_t [FWD_STAGES-1:0] slots_q, slots_d;
  logic [FW-1:0]             idx_a, idx_b;
  logic [FW-1:0]             fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic                      hit_a, hit_b, ld_a, ld_b;
  logic                      stall, issue;
  logic [REG_AW-1:0]         rs1_in, rs2_in, rd_in;

  assign rs1_in = bus.id_rs1;
  assign rs2_in = bus.id_rs2;
  assign rd_in  = bus.id_rd;

  haz_src_match #(
    .FWD_STAGES (FWD_STAGES),
    .FW         (FW)
  ) u_match_a (
    .rs      (RegAwMax'(rs1_in)),
    .use_rs  (bus.id_use_rs1),
    .slots   (slots_q),
    .index   (idx_a),
    .hit     (hit_a),
    .is_load (ld_a)
  );

  haz_src_match #(
    .FWD_STAGES (FWD_STAGES),
    .FW         (FW)
  ) u_match_b (
    .rs      (RegAwMax'(rs2_in)),
    .use_rs  (bus.id_use_rs2),
    .slots   (slots_q),
    .index   (idx_b),
    .hit     (hit_b),
    .is_load (ld_b)
  );

  // A load is not forwardable until it reaches source index LOAD_LAT+1.
  assign stall = bus.id_valid & ((hit_a & ld_a & (idx_a <= LoadIdx)) |
                                 (hit_b & ld_b & (idx_b <= LoadIdx)));
  assign issue = bus.id_valid & ~stall & ~bus.redirect;

  always_comb begin
    slots_d            = '0;
    slots_d[0].valid   = issue & bus.id_regwrite & (rd_in != '0);
    slots_d[0].rd      = RegAwMax'(rd_in);
    slots_d[0].is_load = bus.id_is_load;
    for (int unsigned j = 1; j < FWD_STAGES; j++) begin
      slots_d[j] = slots_q[j-1];
      // Redirect kills the youngest slots before they shift on.
      if (bus.redirect && ((j - 1) < KILL_SLOTS)) begin
        slots_d[j].valid = 1'b0;
      end
    end
  end

  assign fwd_a_d = issue ? idx_a : FW'(FWD_RF);
  assign fwd_b_d = issue ? idx_b : FW'(FWD_RF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots_q <= '0;
      fwd_a_q <= FW'(FWD_RF);
      fwd_b_q <= FW'(FWD_RF);
    end else begin
      slots_q <= slots_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.fwd_a = fwd_a_q;
  assign bus.fwd_b = fwd_b_q;

  // Redirect outranks the load-use stall; everything idles while reset is held.
  always_comb begin
    bus.en_pc       = 1'b1;
    bus.en_ifid     = 1'b1;
    bus.flush_ifid  = 1'b0;
    bus.bubble_idex = 1'b0;
    if (rst) begin
      if (bus.redirect) begin
        bus.flush_ifid  = 1'b1;
        bus.bubble_idex = 1'b1;
      end else if (stall) begin
        bus.en_pc       = 1'b0;
        bus.en_ifid     = 1'b0;
        bus.bubble_idex = 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stalls_q, perf_flushes_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (stall && !bus.redirect && (perf_stalls_q != 32'hFFFF_FFFF)) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
      if (bus.redirect && (perf_flushes_q != 32'hFFFF_FFFF)) begin
        perf_flushes_q <= perf_flushes_q + 32'd1;
      end
    end
  end

  assign bus.perf_stalls  = perf_stalls_q;
  assign bus.perf_flushes = perf_flushes_q;
`else
  assign bus.perf_stalls  = '0;
  assign bus.perf_flushes = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: a default build and a deeper (3 stage, 2-cycle load) build.
module tb_pipe_hazard_scoreboard;
  import haz_pkg::*;

  localparam int unsigned FsA = 2, LlA = 1, KsA = 1;
  localparam int unsigned FsB = 3, LlB = 2, KsB = 2;
  localparam int unsigned FwA = fwd_w(FsA);
  localparam int unsigned FwB = fwd_w(FsB);
`ifdef HAZ_PERF_CNT_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid = 0, u1 = 0, u2 = 0, rw = 0, ld = 0, redirect = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;

  pipe_hazard_scoreboard_if #(.REG_AW(5), .FW(FwA)) ifa ();
  pipe_hazard_scoreboard_if #(.REG_AW(5), .FW(FwB)) ifb ();

  always_comb begin
    ifa.id_valid = id_valid; ifa.id_rs1 = rs1; ifa.id_rs2 = rs2; ifa.id_use_rs1 = u1;
    ifa.id_use_rs2 = u2; ifa.id_rd = rd; ifa.id_regwrite = rw; ifa.id_is_load = ld;
    ifa.redirect = redirect;
    ifb.id_valid = id_valid; ifb.id_rs1 = rs1; ifb.id_rs2 = rs2; ifb.id_use_rs1 = u1;
    ifb.id_use_rs2 = u2; ifb.id_rd = rd; ifb.id_regwrite = rw; ifb.id_is_load = ld;
    ifb.redirect = redirect;
  end

  pipe_hazard_scoreboard #(
    .REG_AW(5), .FWD_STAGES(FsA), .LOAD_LAT(LlA), .KILL_SLOTS(KsA)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  pipe_hazard_scoreboard #(
    .REG_AW(5), .FWD_STAGES(FsB), .LOAD_LAT(LlB), .KILL_SLOTS(KsB)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a list of in-flight writers tagged with their age since entering EX.
  int unsigned fs [2] = '{FsA, FsB};
  int unsigned ll [2] = '{LlA, LlB};
  int unsigned ks [2] = '{KsA, KsB};
  bit          rv   [2][8];
  logic [4:0]  rrd  [2][8];
  bit          rld  [2][8];
  int          rage [2][8];
  int          exp_fa [2];
  int          exp_fb [2];
  int unsigned ps [2];
  int unsigned pf [2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void mdl_reset(int d);
    for (int i = 0; i < 8; i++) rv[d][i] = 1'b0;
    exp_fa[d] = 0; exp_fb[d] = 0; ps[d] = 0; pf[d] = 0;
  endfunction

  function automatic void src_look(int d, logic [4:0] rs, bit use_r, output int idx,
                                   output bit stl);
    int best = 1000;
    bit best_ld = 1'b0;
    idx = 0; stl = 1'b0;
    if (use_r && rs != 5'd0) begin
      for (int i = 0; i < 8; i++) begin
        if (rv[d][i] && rrd[d][i] == rs && rage[d][i] < best) begin
          best = rage[d][i]; best_ld = rld[d][i];
        end
      end
    end
    if (best < 1000) begin
      idx = best + 1;
      stl = best_ld && (idx <= int'(ll[d]));
    end
  endfunction

  function automatic void mdl_comb(int d, output int fa, output int fb, output bit stall);
    bit sa, sb;
    src_look(d, rs1, u1, fa, sa);
    src_look(d, rs2, u2, fb, sb);
    stall = rst && id_valid && (sa || sb);
  endfunction

  function automatic void mdl_clock(int d);
    int fa, fb;
    bit st, iss, placed;
    if (!rst) begin
      mdl_reset(d);
      return;
    end
    mdl_comb(d, fa, fb, st);
    iss = id_valid && !st && !redirect;
    if (st && !redirect && ps[d] != 32'hFFFF_FFFF) ps[d]++;
    if (redirect && pf[d] != 32'hFFFF_FFFF) pf[d]++;
    for (int i = 0; i < 8; i++) begin
      if (rv[d][i]) begin
        if (redirect && rage[d][i] < int'(ks[d])) rv[d][i] = 1'b0;
        else begin
          rage[d][i]++;
          if (rage[d][i] >= int'(fs[d])) rv[d][i] = 1'b0;
        end
      end
    end
    placed = 1'b0;
    if (iss && rw && rd != 5'd0) begin
      for (int i = 0; i < 8; i++) begin
        if (!rv[d][i] && !placed) begin
          rv[d][i] = 1'b1; rrd[d][i] = rd; rld[d][i] = ld; rage[d][i] = 0; placed = 1'b1;
        end
      end
    end
    exp_fa[d] = iss ? fa : 0;
    exp_fb[d] = iss ? fb : 0;
  endfunction

  task automatic check_now();
    int fa, fb;
    bit st;
    logic o_en_pc, o_en_ifid, o_flush, o_bub;
    logic [31:0] o_fa, o_fb, o_ps, o_pf;
    string p;
    for (int d = 0; d < 2; d++) begin
      mdl_comb(d, fa, fb, st);
      if (d == 0) begin
        p = "a";
        o_en_pc = ifa.en_pc; o_en_ifid = ifa.en_ifid; o_flush = ifa.flush_ifid;
        o_bub = ifa.bubble_idex; o_fa = 32'(ifa.fwd_a); o_fb = 32'(ifa.fwd_b);
        o_ps = ifa.perf_stalls; o_pf = ifa.perf_flushes;
      end else begin
        p = "b";
        o_en_pc = ifb.en_pc; o_en_ifid = ifb.en_ifid; o_flush = ifb.flush_ifid;
        o_bub = ifb.bubble_idex; o_fa = 32'(ifb.fwd_a); o_fb = 32'(ifb.fwd_b);
        o_ps = ifb.perf_stalls; o_pf = ifb.perf_flushes;
      end
      chk({p, "_en_pc"},   32'(o_en_pc),   32'(!(st && !redirect)));
      chk({p, "_en_ifid"}, 32'(o_en_ifid), 32'(!(st && !redirect)));
      chk({p, "_flush"},   32'(o_flush),   32'(rst && redirect));
      chk({p, "_bubble"},  32'(o_bub),     32'((rst && redirect) || st));
      chk({p, "_fwd_a"},   o_fa, 32'(exp_fa[d]));
      chk({p, "_fwd_b"},   o_fb, 32'(exp_fb[d]));
      chk({p, "_perf_st"}, o_ps, PerfOn ? ps[d] : 32'd0);
      chk({p, "_perf_fl"}, o_pf, PerfOn ? pf[d] : 32'd0);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_now();
    @(posedge clk);
    mdl_clock(0);
    mdl_clock(1);
    #1;
  endtask

  task automatic set_id(bit v, logic [4:0] a, bit ua, logic [4:0] b, bit ub, logic [4:0] dst,
                        bit w, bit l);
    id_valid = v; rs1 = a; u1 = ua; rs2 = b; u2 = ub; rd = dst; rw = w; ld = l;
  endtask

  task automatic nops(int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) cyc();
  endtask

  initial begin
    mdl_reset(0);
    mdl_reset(1);
    nops(2);
    rst = 1'b1;
    nops(1);

    // Plain forwarding distance.
    set_id(1, 0, 0, 0, 0, 5, 1, 0); cyc();
    set_id(1, 5, 1, 0, 0, 10, 1, 0); cyc();
    chk("t1_adj_fwd_a", 32'(ifa.fwd_a), 1);
    set_id(1, 0, 0, 0, 0, 5, 1, 0); cyc();
    set_id(1, 0, 0, 0, 0, 11, 1, 0); cyc();
    set_id(1, 5, 1, 0, 0, 10, 1, 0); cyc();
    chk("t1_gap1_fwd_a", 32'(ifa.fwd_a), 2);
    set_id(1, 0, 0, 0, 0, 5, 1, 0); cyc();
    set_id(1, 0, 0, 0, 0, 11, 1, 0); cyc();
    set_id(1, 0, 0, 0, 0, 12, 1, 0); cyc();
    set_id(1, 5, 1, 0, 0, 10, 1, 0); cyc();
    chk("t1_gap2_fwd_a", 32'(ifa.fwd_a), 0);
    chk("t1_gap2_fwd_a_deep", 32'(ifb.fwd_a), 3);

    // Load-use with default latency.
    nops(3);
    set_id(1, 0, 0, 0, 0, 6, 1, 1); cyc();
    set_id(1, 0, 0, 6, 1, 12, 1, 0);
    #2;
    chk("t2_en_pc", 32'(ifa.en_pc), 0);
    chk("t2_en_ifid", 32'(ifa.en_ifid), 0);
    chk("t2_bubble", 32'(ifa.bubble_idex), 1);
    cyc();
    #2;
    chk("t2_released", 32'(ifa.en_pc), 1);
    cyc();
    chk("t2_fwd_b", 32'(ifa.fwd_b), 2);
    chk("t2_perf_stalls", ifa.perf_stalls, PerfOn ? 32'd1 : 32'd0);

    // Two-cycle load latency on the deep build.
    nops(4);
    set_id(1, 0, 0, 0, 0, 7, 1, 1); cyc();
    set_id(1, 7, 1, 0, 0, 13, 1, 0);
    #2; chk("t3_stall1", 32'(ifb.en_pc), 0);
    cyc();
    #2; chk("t3_stall2", 32'(ifb.en_pc), 0);
    cyc();
    #2; chk("t3_go", 32'(ifb.en_pc), 1);
    cyc();
    chk("t3_fwd_a", 32'(ifb.fwd_a), 3);

    // Youngest producer wins; x0 never matches.
    nops(4);
    set_id(1, 0, 0, 0, 0, 8, 1, 0); cyc();
    set_id(1, 0, 0, 0, 0, 8, 1, 0); cyc();
    set_id(1, 8, 1, 8, 1, 14, 1, 0); cyc();
    chk("t4_young_a", 32'(ifa.fwd_a), 1);
    chk("t4_young_b", 32'(ifa.fwd_b), 1);
    set_id(1, 0, 0, 0, 0, 9, 1, 0); cyc();
    set_id(1, 0, 0, 0, 0, 8, 1, 0); cyc();
    set_id(1, 8, 1, 9, 1, 14, 1, 0); cyc();
    chk("t4_split_a", 32'(ifa.fwd_a), 1);
    chk("t4_split_b", 32'(ifa.fwd_b), 2);
    set_id(1, 0, 0, 0, 0, 0, 1, 1); cyc();
    set_id(1, 0, 1, 0, 1, 15, 1, 0);
    #2; chk("t4_x0_nostall", 32'(ifa.en_pc), 1);
    cyc();
    chk("t4_x0_fwd_a", 32'(ifa.fwd_a), 0);

    // Redirect beats a pending load-use stall.
    nops(4);
    set_id(1, 0, 0, 0, 0, 6, 1, 1); cyc();
    set_id(1, 0, 0, 6, 1, 12, 1, 0);
    redirect = 1'b1;
    #2;
    chk("t5_flush", 32'(ifa.flush_ifid), 1);
    chk("t5_bubble", 32'(ifa.bubble_idex), 1);
    chk("t5_en_pc", 32'(ifa.en_pc), 1);
    chk("t5_en_ifid", 32'(ifa.en_ifid), 1);
    cyc();
    redirect = 1'b0;
    #2; chk("t5_killed", 32'(ifa.en_pc), 1);
    cyc();
    chk("t5_fwd_b", 32'(ifa.fwd_b), 0);

    // Asynchronous reset in the middle of a stall.
    nops(4);
    set_id(1, 0, 0, 0, 0, 20, 1, 0); cyc();
    set_id(1, 20, 1, 0, 0, 6, 1, 1); cyc();
    set_id(1, 0, 0, 6, 1, 12, 1, 0);
    #1;
    chk("t6_pre_stall", 32'(ifa.en_pc), 0);
    chk("t6_pre_fwd_a", 32'(ifa.fwd_a), 1);
    rst = 1'b0;
    mdl_reset(0);
    mdl_reset(1);
    #1;
    chk("t6_rst_en_pc", 32'(ifa.en_pc), 1);
    chk("t6_rst_fwd_a", 32'(ifa.fwd_a), 0);
    chk("t6_rst_fwd_b", 32'(ifa.fwd_b), 0);
    chk("t6_rst_en_pc_deep", 32'(ifb.en_pc), 1);
    cyc();
    rst = 1'b1;
    #2; chk("t6_after_nostall", 32'(ifa.en_pc), 1);
    cyc();
    chk("t6_after_fwd_b", 32'(ifa.fwd_b), 0);

    // Randomized traffic against the model.
    repeat (400) begin
      id_valid = ($urandom_range(0, 9) != 0);
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      u1  = id_valid && ($urandom_range(0, 3) != 0);
      u2  = id_valid && ($urandom_range(0, 1) != 0);
      rw  = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 2) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      cyc();
    end
    redirect = 1'b0;
    nops(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
- Parametrised successor to the fixed 2-source forwarding and load-use hazard logic of the in-order RISC-V pipeline.
- Tracks in-flight register writers in a scoreboard shift register with a configurable number of post-EX stages and configurable load latency.
- Issues registered forward selects, stall/bubble and redirect-flush controls.
- Sits beside the ID stage; drives the PC enable, the IF/ID enable/flush, the ID/EX bubble/flush and the EX operand muxes.

Parameters:
- REG_AW, 5, register address width (2**REG_AW architectural regs; x0 never a producer)
- FWD_STAGES, 2, post-EX stages able to forward (1 = EX/MEM, 2 = MEM/WB, ...); also scoreboard depth
- LOAD_LAT, 1, cycles after EX before load data is forwardable; load result is usable from source index LOAD_LAT+1; range 0..FWD_STAGES-1
- KILL_SLOTS, 1, youngest scoreboard slots invalidated on redirect; range 0..FWD_STAGES

Ports:
- clk, in, 1, clock
- rst, in, 1, reset, asynchronous, active-low
- id_valid, in, 1, ID holds a real instruction
- id_rs1, in, REG_AW, source 1 address
- id_rs2, in, REG_AW, source 2 address
- id_use_rs1, in, 1, instruction reads rs1
- id_use_rs2, in, 1, instruction reads rs2
- id_rd, in, REG_AW, destination address
- id_regwrite, in, 1, instruction writes rd
- id_is_load, in, 1, instruction is a load
- redirect, in, 1, taken branch/jump resolved downstream (pcsrc)
- en_pc, out, 1, PC update enable
- en_ifid, out, 1, IF/ID enable
- flush_ifid, out, 1, IF/ID clear
- bubble_idex, out, 1, load ID/EX with a NOP (control bits zero)
- fwd_a, out, FW, EX operand A source; FW = $clog2(FWD_STAGES+1); 0 = register file, k = stage k past EX
- fwd_b, out, FW, EX operand B source, same encoding
- perf_stalls, out, 32, load-use stall cycles (optional feature)
- perf_flushes, out, 32, redirect cycles (optional feature)

Behaviour:
- Scoreboard: FWD_STAGES slots {valid, rd, is_load}. Slot 0 is the instruction now in EX; slot j is j stages past EX. Every cycle the slots shift j→j+1 and the oldest is dropped.
- Issue: slot 0 ← {id_valid & id_regwrite & (id_rd != 0), id_rd, id_is_load} when the instruction issues. Otherwise slot 0 ← invalid.
- Match, per source: search slots 0..FWD_STAGES-1 for valid & rd == rs & use_rs. The youngest (lowest j) wins. The source index is j+1, the position of the producer when the consumer reaches EX.
  - If the youngest match has j+1 > FWD_STAGES, or there is no match, the source is the register file. The regfile is write-through.
- Load-use stall, combinational: any used source whose youngest match is a load with j+1 < LOAD_LAT+1 asserts the stall.
  - Stall forces en_pc=0, en_ifid=0, bubble_idex=1 and slot 0 invalid.
  - The stall repeats each cycle until the producer has advanced far enough.
- Forward selects are registered. On issue, fwd_a/fwd_b ← computed indices. On bubble or flush they ← 0. They are valid while the consumer is in EX.
- Redirect has priority over stall:
  - Outputs: flush_ifid=1, bubble_idex=1, en_pc=1, en_ifid=1.
  - Scoreboard: slots 0..KILL_SLOTS-1 are invalidated before shifting, and the ID instruction does not issue.
- Idle outputs: en_pc=1, en_ifid=1, all others 0.
- Reset, asynchronous, rst low: all slots invalid and fwd_a=fwd_b=0. Combinational outputs follow the idle values while in reset. Reset mid-stall drops the stall immediately.
- id_rs == 0 never matches, even with use asserted. Both sources may match different slots in the same cycle.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined: perf_stalls increments on each cycle with stall & ~redirect. perf_flushes increments on each redirect cycle. Both are 32-bit, saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: no counters are synthesised and both ports are tied to 0.

Decomposition:
- Shared package haz_pkg:
  - FWD_RF constant (0).
  - fwd_w(FWD_STAGES) function returning FW.
  - Scoreboard slot struct/typedef {valid, rd, is_load}.
- Sub-module haz_src_match: one source address against all slots, with youngest-priority encoder. Outputs: index, hit, is_load of the hit. Instantiated twice (rs1, rs2).

Test Plan:
- Defaults. Issue add x5 (regwrite). Next cycle issue add rs1=x5 → fwd_a=1, no stall. With one unrelated instruction between them → fwd_a=2. With two between → fwd_a=0.
- Defaults. Issue lw x6. Next cycle ID holds add rs2=x6 → one cycle with en_pc=0, en_ifid=0, bubble_idex=1. Then it issues with fwd_b=2. perf_stalls=1 with the macro defined, 0 without.
- LOAD_LAT=2, FWD_STAGES=3. lw x7 followed immediately by a consumer → two stall cycles, then fwd_a=3.
- Producers x8 (older) and x8 (younger) both in flight. Consumer reads x8 → the younger one's index is selected. Consumer reads rs1=x0 with x0 "writer" injected → fwd_a=0, no stall.
- Load-use stall pending and redirect=1 in the same cycle → flush_ifid=1, bubble_idex=1, en_pc=1, no stall. Slot 0 is invalid next cycle.
- rst pulsed low mid-stall, asynchronously between clock edges → en_pc=1 and fwd_a=fwd_b=0 immediately. After release, an old producer's rd does not match.
